// File: rtl/axi_txn_pkg.sv
// Shared types for the AXI write transaction tracker: queued AW records,
// pending-B records and the write response encoding.
package axi_txn_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_ID_W   = 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_ID_W-1:0]   id;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [31:0]           ts;
  } aw_rec_t;

  // age = number of older live entries in the pending table (0 = oldest)
  typedef struct packed {
    aw_rec_t    aw;
    logic [7:0] age;
  } pend_rec_t;

endpackage

// File: rtl/axi_write_txn_tracker_if.sv
// Observed AXI4 write channels; the bench drives through master, the tracker
// only listens through slave.
interface axi_write_txn_tracker_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8
);
  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic                  w_valid;
  logic                  w_ready;
  logic                  w_last;
  logic                  b_valid;
  logic                  b_ready;
  logic [ID_WIDTH-1:0]   b_id;
  logic [1:0]            b_resp;

  modport master (
    output aw_valid, aw_ready, aw_addr, aw_id, aw_len, aw_size, aw_burst,
           w_valid, w_ready, w_last, b_valid, b_ready, b_id, b_resp
  );

  modport slave (
    input aw_valid, aw_ready, aw_addr, aw_id, aw_len, aw_size, aw_burst,
          w_valid, w_ready, w_last, b_valid, b_ready, b_id, b_resp
  );
endinterface

// File: rtl/axi_txn_fifo.sv
// Synchronous FIFO of an arbitrary record type; DEPTH must be a power of 2
// and at least 2. Pushes while full and pops while empty are ignored.
module axi_txn_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic empty,
  output logic full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/axi_write_txn_tracker.sv
// Passive AXI4 write tracker: pairs AW, W bursts and B responses into
// completion records and flags protocol errors for the logging monitor.
module axi_write_txn_tracker
  import axi_txn_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_W,
  parameter int ID_WIDTH   = AXI_ID_W,
  parameter int AW_DEPTH   = 8,
  parameter int PEND_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_write_txn_tracker_if.slave  axi,
  output logic                    txn_done,
  output logic [ID_WIDTH-1:0]     txn_id,
  output logic [ADDR_WIDTH-1:0]   txn_addr,
  output logic [7:0]              txn_len,
  output logic [1:0]              txn_resp,
  output logic [31:0]             txn_latency,
  output logic                    err_wlast,
  output logic                    err_w_no_aw,
  output logic                    err_b_orphan,
  output logic                    err_overflow,
  output logic [7:0]              outstanding
);
  localparam int PW = $clog2(PEND_DEPTH);

  logic [31:0]     cycle_cnt;
  logic [7:0]      bcnt;
  aw_rec_t         aw_in;
  aw_rec_t         aw_head;
  logic            aw_empty;
  logic            aw_full;
  logic            aw_hs, w_hs, b_hs;
  logic            aw_push, aw_drop;
  logic            w_beat, last_exp, burst_end;
  logic            pend_ins, pend_drop;
  pend_rec_t       pend_tbl [PEND_DEPTH];
  logic [PEND_DEPTH-1:0] pend_vld;
  logic [PW:0]     pend_cnt;
  logic            b_hit, b_take, free_ok;
  logic [PW-1:0]   hit_idx, free_idx;
  logic [7:0]      hit_age;

  assign aw_hs = axi.aw_valid && axi.aw_ready;
  assign w_hs  = axi.w_valid && axi.w_ready;
  assign b_hs  = axi.b_valid && axi.b_ready;

  assign aw_in = '{addr:  AXI_ADDR_W'(axi.aw_addr),
                   id:    AXI_ID_W'(axi.aw_id),
                   len:   axi.aw_len,
                   size:  axi.aw_size,
                   burst: axi.aw_burst,
                   ts:    cycle_cnt};

  assign aw_push   = aw_hs && !aw_full;
  assign aw_drop   = aw_hs && aw_full;
  // head is registered, so an AW pushed this cycle is invisible to this beat
  assign w_beat    = w_hs && !aw_empty;
  assign last_exp  = (bcnt == aw_head.len);
  assign burst_end = w_beat && last_exp;
  assign pend_ins  = burst_end && free_ok;
  assign pend_drop = burst_end && !free_ok;
  assign b_take    = b_hs && b_hit;

  axi_txn_fifo #(.T(aw_rec_t), .DEPTH(AW_DEPTH)) u_aw_q (
    .clk   (clk),
    .rst   (rst),
    .push  (aw_push),
    .din   (aw_in),
    .pop   (burst_end),
    .dout  (aw_head),
    .empty (aw_empty),
    .full  (aw_full)
  );

  // Oldest matching ID wins; lowest free slot takes the next insert.
  always_comb begin
    b_hit    = 1'b0;
    hit_idx  = '0;
    hit_age  = '1;
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = 0; i < PEND_DEPTH; i++) begin
      if (pend_vld[i] && pend_tbl[i].aw.id == AXI_ID_W'(axi.b_id) &&
          (!b_hit || pend_tbl[i].age < hit_age)) begin
        b_hit   = 1'b1;
        hit_idx = PW'(i);
        hit_age = pend_tbl[i].age;
      end
    end
    for (int i = PEND_DEPTH - 1; i >= 0; i--) begin
      if (!pend_vld[i]) begin
        free_ok  = 1'b1;
        free_idx = PW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld <= '0;
      pend_cnt <= '0;
    end else begin
      if (b_take) begin
        pend_vld[hit_idx] <= 1'b0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
          if (pend_vld[i] && pend_tbl[i].age > hit_age)
            pend_tbl[i].age <= pend_tbl[i].age - 8'd1;
        end
      end
      if (pend_ins) begin
        pend_vld[free_idx] <= 1'b1;
        pend_tbl[free_idx] <= '{aw: aw_head, age: 8'(pend_cnt) - 8'(b_take)};
      end
      pend_cnt <= pend_cnt + (PW+1)'(pend_ins) - (PW+1)'(b_take);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt    <= '0;
      bcnt         <= '0;
      txn_done     <= 1'b0;
      txn_id       <= '0;
      txn_addr     <= '0;
      txn_len      <= '0;
      txn_resp     <= '0;
      txn_latency  <= '0;
      err_wlast    <= 1'b0;
      err_w_no_aw  <= 1'b0;
      err_b_orphan <= 1'b0;
      err_overflow <= 1'b0;
      outstanding  <= '0;
    end else begin
      cycle_cnt    <= cycle_cnt + 32'd1;
      txn_done     <= b_take;
      if (b_take) begin
        txn_id      <= ID_WIDTH'(pend_tbl[hit_idx].aw.id);
        txn_addr    <= ADDR_WIDTH'(pend_tbl[hit_idx].aw.addr);
        txn_len     <= pend_tbl[hit_idx].aw.len;
        txn_resp    <= axi.b_resp;
        txn_latency <= cycle_cnt - pend_tbl[hit_idx].aw.ts;
      end
      err_wlast    <= w_beat && (axi.w_last != last_exp);
      err_w_no_aw  <= w_hs && aw_empty;
      err_b_orphan <= b_hs && !b_hit;
      if (aw_drop || pend_drop) err_overflow <= 1'b1;
      outstanding  <= outstanding + 8'(aw_push) - 8'(pend_drop) - 8'(b_take);
      if (burst_end)   bcnt <= '0;
      else if (w_beat) bcnt <= bcnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_axi_write_txn_tracker.sv
// Bench for axi_write_txn_tracker: per-cycle vector table with a completion
// scoreboard, plus hand sequences for AW overflow and mid-burst reset.
module tb_axi_write_txn_tracker;
  import axi_txn_pkg::*;

  typedef struct {
    logic        rdy;
    logic        aw_v;
    logic [7:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic        w_v;
    logic        w_last;
    logic        b_v;
    logic [7:0]  b_id;
    logic [1:0]  b_resp;
    logic        e_wlast;
    logic        e_noaw;
    logic        e_orphan;
    logic [7:0]  e_out;
    logic        e_done;
    logic [31:0] e_addr;
    logic [7:0]  e_len;
    logic [31:0] e_lat;
  } vec_t;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  resp;
    logic [31:0] lat;
  } exp_t;

  localparam int NV = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        txn_done;
  logic [7:0]  txn_id;
  logic [31:0] txn_addr;
  logic [7:0]  txn_len;
  logic [1:0]  txn_resp;
  logic [31:0] txn_latency;
  logic        err_wlast, err_w_no_aw, err_b_orphan, err_overflow;
  logic [7:0]  outstanding;

  int   checks = 0;
  int   errors = 0;
  int   n_exp  = 0;
  int   n_done = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[NV];

  axi_write_txn_tracker_if #(.ADDR_WIDTH(32), .ID_WIDTH(8)) axi ();

  axi_write_txn_tracker #(.ADDR_WIDTH(32), .ID_WIDTH(8), .AW_DEPTH(8), .PEND_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .axi          (axi),
    .txn_done     (txn_done),
    .txn_id       (txn_id),
    .txn_addr     (txn_addr),
    .txn_len      (txn_len),
    .txn_resp     (txn_resp),
    .txn_latency  (txn_latency),
    .err_wlast    (err_wlast),
    .err_w_no_aw  (err_w_no_aw),
    .err_b_orphan (err_b_orphan),
    .err_overflow (err_overflow),
    .outstanding  (outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rdy, aw_v, input logic [7:0] aw_id,
                              input logic [31:0] aw_addr, input logic [7:0] aw_len,
                              input logic w_v, w_last, b_v, input logic [7:0] b_id,
                              input logic [1:0] b_resp, input logic e_wl, e_na, e_or,
                              input logic [7:0] e_out, input logic e_done,
                              input logic [31:0] e_addr, input logic [7:0] e_len,
                              input logic [31:0] e_lat);
    vec_t v;
    v = '{rdy, aw_v, aw_id, aw_addr, aw_len, w_v, w_last, b_v, b_id, b_resp,
          e_wl, e_na, e_or, e_out, e_done, e_addr, e_len, e_lat};
    return v;
  endfunction

  task automatic idle_bus();
    axi.aw_valid = 1'b0; axi.w_valid = 1'b0; axi.b_valid = 1'b0;
    axi.aw_ready = 1'b1; axi.w_ready = 1'b1; axi.b_ready = 1'b1;
    axi.aw_addr = '0; axi.aw_id = '0; axi.aw_len = '0;
    axi.aw_size = 3'd2; axi.aw_burst = 2'b01;
    axi.w_last = 1'b0; axi.b_id = '0; axi.b_resp = '0;
  endtask

  // Drive one cycle at a negedge, check registered results at the next negedge.
  task automatic apply(input vec_t v);
    axi.aw_ready = v.rdy;  axi.w_ready = v.rdy;  axi.b_ready = v.rdy;
    axi.aw_valid = v.aw_v; axi.aw_id = v.aw_id; axi.aw_addr = v.aw_addr;
    axi.aw_len   = v.aw_len;
    axi.w_valid  = v.w_v;  axi.w_last = v.w_last;
    axi.b_valid  = v.b_v;  axi.b_id = v.b_id;   axi.b_resp = v.b_resp;
    if (v.e_done) begin
      exp_q.push_back('{v.b_id, v.e_addr, v.e_len, v.b_resp, v.e_lat});
      n_exp++;
    end
    @(negedge clk);
    chk("err_wlast",    {31'd0, err_wlast},    {31'd0, v.e_wlast});
    chk("err_w_no_aw",  {31'd0, err_w_no_aw},  {31'd0, v.e_noaw});
    chk("err_b_orphan", {31'd0, err_b_orphan}, {31'd0, v.e_orphan});
    chk("outstanding",  {24'd0, outstanding},  {24'd0, v.e_out});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_txn_done"},     {31'd0, txn_done},     32'd0);
    chk({tag, "_txn_id"},       {24'd0, txn_id},       32'd0);
    chk({tag, "_txn_addr"},     txn_addr,              32'd0);
    chk({tag, "_txn_len"},      {24'd0, txn_len},      32'd0);
    chk({tag, "_txn_resp"},     {30'd0, txn_resp},     32'd0);
    chk({tag, "_txn_latency"},  txn_latency,           32'd0);
    chk({tag, "_err_wlast"},    {31'd0, err_wlast},    32'd0);
    chk({tag, "_err_w_no_aw"},  {31'd0, err_w_no_aw},  32'd0);
    chk({tag, "_err_b_orphan"}, {31'd0, err_b_orphan}, 32'd0);
    chk({tag, "_err_overflow"}, {31'd0, err_overflow}, 32'd0);
    chk({tag, "_outstanding"},  {24'd0, outstanding},  32'd0);
  endtask

  // Completion scoreboard
  always @(negedge clk) begin
    if (txn_done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_txn_done_id", {24'd0, txn_id}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("txn_id",      {24'd0, txn_id},  {24'd0, mon_e.id});
        chk("txn_addr",    txn_addr,         mon_e.addr);
        chk("txn_len",     {24'd0, txn_len}, {24'd0, mon_e.len});
        chk("txn_resp",    {30'd0, txn_resp}, {30'd0, mon_e.resp});
        chk("txn_latency", txn_latency,      mon_e.lat);
      end
    end
  end

  initial begin
    //                rdy aw id     addr     len w wl b bid    resp         ewl ena eor out done addr     len lat
    vecs[0]  = mk(1, 1, 8'h03, 32'h100, 8'd3, 0, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0);
    vecs[1]  = mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0);
    vecs[2]  = mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0);
    vecs[3]  = mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0);
    vecs[4]  = mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 1, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0);
    vecs[5]  = mk(1, 0, 8'h00, 32'h0,   8'd0, 0, 0, 1, 8'h03, RESP_OKAY,   0, 0, 0, 0, 1, 32'h100, 3, 5);
    vecs[6]  = mk(1, 1, 8'h04, 32'h200, 8'd1, 0, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0);
    vecs[7]  = mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 1, 0, 8'h00, RESP_OKAY,   1, 0, 0, 1, 0, 32'h0,   0, 0);
    vecs[8]  = mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 1, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0);
    vecs[9]  = mk(1, 0, 8'h00, 32'h0,   8'd0, 0, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0);
    vecs[10] = mk(1, 0, 8'h00, 32'h0,   8'd0, 0, 0, 1, 8'h04, RESP_SLVERR, 0, 0, 0, 0, 1, 32'h200, 1, 4);
    vecs[11] = mk(1, 1, 8'h01, 32'h300, 8'd0, 0, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0);
    vecs[12] = mk(1, 1, 8'h02, 32'h400, 8'd0, 0, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 2, 0, 32'h0,   0, 0);
    vecs[13] = mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 1, 0, 8'h00, RESP_OKAY,   0, 0, 0, 2, 0, 32'h0,   0, 0);
    vecs[14] = mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 1, 0, 8'h00, RESP_OKAY,   0, 0, 0, 2, 0, 32'h0,   0, 0);
    vecs[15] = mk(1, 0, 8'h00, 32'h0,   8'd0, 0, 0, 1, 8'h02, RESP_EXOKAY, 0, 0, 0, 1, 1, 32'h400, 0, 3);
    vecs[16] = mk(1, 0, 8'h00, 32'h0,   8'd0, 0, 0, 1, 8'h01, RESP_OKAY,   0, 0, 0, 0, 1, 32'h300, 0, 5);
    vecs[17] = mk(1, 1, 8'h05, 32'h500, 8'd0, 1, 1, 0, 8'h00, RESP_OKAY,   0, 1, 0, 1, 0, 32'h0,   0, 0);
    vecs[18] = mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 1, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0);
    vecs[19] = mk(1, 1, 8'h05, 32'h600, 8'd0, 0, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 2, 0, 32'h0,   0, 0);
    vecs[20] = mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 1, 0, 8'h00, RESP_OKAY,   0, 0, 0, 2, 0, 32'h0,   0, 0);
    vecs[21] = mk(1, 0, 8'h00, 32'h0,   8'd0, 0, 0, 1, 8'h05, RESP_OKAY,   0, 0, 0, 1, 1, 32'h500, 0, 4);
    vecs[22] = mk(1, 0, 8'h00, 32'h0,   8'd0, 0, 0, 1, 8'h05, RESP_DECERR, 0, 0, 0, 0, 1, 32'h600, 0, 3);
    vecs[23] = mk(1, 0, 8'h00, 32'h0,   8'd0, 0, 0, 1, 8'h07, RESP_OKAY,   0, 0, 1, 0, 0, 32'h0,   0, 0);
    vecs[24] = mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 0, 0, 8'h00, RESP_OKAY,   0, 1, 0, 0, 0, 32'h0,   0, 0);
    vecs[25] = mk(1, 1, 8'h06, 32'h700, 8'd0, 0, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0);
    vecs[26] = mk(1, 1, 8'h08, 32'h800, 8'd1, 1, 1, 0, 8'h00, RESP_OKAY,   0, 0, 0, 2, 0, 32'h0,   0, 0);
    vecs[27] = mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 2, 0, 32'h0,   0, 0);
    vecs[28] = mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 1, 1, 8'h06, RESP_OKAY,   0, 0, 0, 1, 1, 32'h700, 0, 3);
    vecs[29] = mk(1, 0, 8'h00, 32'h0,   8'd0, 0, 0, 1, 8'h08, RESP_OKAY,   0, 0, 0, 0, 1, 32'h800, 1, 3);
    vecs[30] = mk(1, 1, 8'h09, 32'h900, 8'd0, 0, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0);
    vecs[31] = mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 1, 1, 8'h09, RESP_OKAY,   0, 0, 1, 1, 0, 32'h0,   0, 0);
    vecs[32] = mk(1, 0, 8'h00, 32'h0,   8'd0, 0, 0, 1, 8'h09, RESP_SLVERR, 0, 0, 0, 0, 1, 32'h900, 0, 2);
    vecs[33] = mk(0, 1, 8'h33, 32'hB00, 8'd0, 1, 1, 1, 8'h33, RESP_OKAY,   0, 0, 0, 0, 0, 32'h0,   0, 0);

    idle_bus();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < NV; i++) apply(vecs[i]);
    idle_bus();
    @(negedge clk);
    chk("no_overflow_yet", {31'd0, err_overflow}, 32'd0);

    // Nine AWs into an eight-entry queue
    for (int i = 0; i < 9; i++) begin
      apply(mk(1, 1, 8'(16 + i), 32'h1000 + 32'(i), 8'd0, 0, 0, 0, 8'h00, RESP_OKAY,
               0, 0, 0, (i < 8) ? 8'(i + 1) : 8'd8, 0, 32'h0, 0, 0));
      chk("err_overflow_step", {31'd0, err_overflow}, (i == 8) ? 32'd1 : 32'd0);
    end
    idle_bus();
    @(negedge clk);
    chk("err_overflow_sticky", {31'd0, err_overflow}, 32'd1);
    chk("outstanding_full", {24'd0, outstanding}, 32'd8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ovf_reset_outstanding", {24'd0, outstanding}, 32'd0);
    chk("ovf_reset_err_overflow", {31'd0, err_overflow}, 32'd0);

    // Give the txn fields non-zero history before the mid-burst reset
    apply(mk(1, 1, 8'h2A, 32'hC00, 8'd0, 0, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0));
    apply(mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 1, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0));
    apply(mk(1, 0, 8'h00, 32'h0,   8'd0, 0, 0, 1, 8'h2A, RESP_DECERR, 0, 0, 0, 0, 1, 32'hC00, 0, 2));
    // Reset with two of four beats sent
    apply(mk(1, 1, 8'h21, 32'hA00, 8'd3, 0, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0));
    apply(mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0));
    apply(mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 0, 0, 8'h00, RESP_OKAY,   0, 0, 0, 1, 0, 32'h0,   0, 0));
    idle_bus();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midburst_reset");
    apply(mk(1, 0, 8'h00, 32'h0,   8'd0, 0, 0, 1, 8'h21, RESP_OKAY,   0, 0, 1, 0, 0, 32'h0,   0, 0));
    apply(mk(1, 0, 8'h00, 32'h0,   8'd0, 1, 1, 0, 8'h00, RESP_OKAY,   0, 1, 0, 0, 0, 32'h0,   0, 0));
    idle_bus();
    repeat (2) @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("txn_done_count", n_done, n_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
